// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall, branch/jump and a
// circular hardware call/return stack. Drives the instruction index every
// cycle; pc_next exposes the would-be value combinationally.
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STEP        = 1,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             branch_valid,
    input  logic [ADDR_WIDTH-1:0]            branch_target,
    input  logic                             call_valid,
    input  logic                             ret_valid,
    input  logic                             clear_flags,
    output logic [ADDR_WIDTH-1:0]            pc,
    output logic [ADDR_WIDTH-1:0]            pc_next,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] STEP_V   = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] RESET_V  = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(STACK_DEPTH - 1);

    // Return-address storage; contents are don't-care after reset.
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    // wr_ptr is the slot the next push writes. When the stack is full that
    // slot holds the oldest entry, so a push there gives the circular
    // overwrite without any extra bookkeeping.
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      wr_ptr_inc;
    logic [PTR_W-1:0]      top_ptr;
    logic [CNT_W-1:0]      count;

    logic [ADDR_WIDTH-1:0] inc;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_oflow;
    logic                  do_uflow;

    // Pointer arithmetic with explicit wrap so non-power-of-two depths work.
    always_comb begin
        wr_ptr_inc  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        top_ptr     = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
        stack_empty = (count == '0);
        stack_full  = (count == FULL_CNT);
    end

    // Request arbitration (ret > call > branch > increment) and next-pc select.
    // branch_target only reaches pc_next when call or branch actually wins.
    always_comb begin
        inc      = pc + STEP_V;
        pc_next  = inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_oflow = 1'b0;
        do_uflow = 1'b0;
        if (ret_valid) begin
            if (!stack_empty) begin
                do_pop  = 1'b1;
                pc_next = stack_mem[top_ptr];
            end else begin
                do_uflow = 1'b1;
            end
        end else if (call_valid) begin
            do_push  = 1'b1;
            do_oflow = stack_full;
            pc_next  = branch_target;
        end else if (branch_valid) begin
            pc_next = branch_target;
        end
    end

    // PC and stack bookkeeping; everything holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_V;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            pc <= pc_next;
            if (do_push) begin
                wr_ptr <= wr_ptr_inc;
                if (!stack_full) begin
                    count <= count + 1'b1;
                end
            end else if (do_pop) begin
                wr_ptr <= top_ptr;
                count  <= count - 1'b1;
            end
        end
    end

    // Sticky error flags: a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            stack_overflow  <= (en & do_oflow) | (stack_overflow  & ~clear_flags);
            stack_underflow <= (en & do_uflow) | (stack_underflow & ~clear_flags);
        end
    end

    // Return-address write; the pushed value is the sequential successor.
    always_ff @(posedge clk) begin
        if (en && do_push) begin
            stack_mem[wr_ptr] <= inc;
        end
    end

    assign stack_count = count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       call_valid;
    logic       ret_valid;
    logic       clear_flags;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [2:0] stack_count;
    logic       stack_overflow;
    logic       stack_underflow;

    // Second instance with STEP=3 for the non-unit wrap case.
    logic       br2;
    logic [7:0] tgt2;
    logic       tie0;
    logic [7:0] pc2;
    logic [7:0] pc_next2;
    logic [2:0] sc2;
    logic       of2;
    logic       uf2;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.ADDR_WIDTH(8), .STEP(1), .RESET_ADDR(0), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .call_valid(call_valid), .ret_valid(ret_valid), .clear_flags(clear_flags),
        .pc(pc), .pc_next(pc_next), .stack_count(stack_count),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    pc_sequencer #(.ADDR_WIDTH(8), .STEP(3), .RESET_ADDR(0), .STACK_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .branch_valid(br2), .branch_target(tgt2),
        .call_valid(tie0), .ret_valid(tie0), .clear_flags(tie0),
        .pc(pc2), .pc_next(pc_next2), .stack_count(sc2),
        .stack_overflow(of2), .stack_underflow(uf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic b,
                         input logic [7:0] t, input logic clr);
        ret_valid     = r;
        call_valid    = c;
        branch_valid  = b;
        branch_target = t;
        clear_flags   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clocked cycle with the given request, then back to idle.
    task automatic cyc(input logic r, input logic c, input logic b,
                       input logic [7:0] t, input logic clr);
        drive(r, c, b, t, clr);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        br2   = 1'b0;
        tgt2  = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] call_tgt [5];
    logic [7:0] ret_exp  [4];

    initial begin
        tie0 = 1'b0;
        call_tgt[0] = 8'h10; call_tgt[1] = 8'h20; call_tgt[2] = 8'h30;
        call_tgt[3] = 8'h40; call_tgt[4] = 8'h50;
        ret_exp[0] = 8'h41; ret_exp[1] = 8'h31; ret_exp[2] = 8'h21; ret_exp[3] = 8'h11;

        // Reset state and sequential increment
        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_count", stack_count, 3'd0);
        check("rst_oflow", stack_overflow, 1'b0);
        check("rst_uflow", stack_underflow, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("inc_%0d", i), pc, 8'(i));
        end

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_pc", pc, 8'h00);
        rst_n = 1'b1;

        // Wrap: STEP=1 from 254, STEP=3 from 253
        br2  = 1'b1;
        tgt2 = 8'd253;
        cyc(1'b0, 1'b0, 1'b1, 8'd254, 1'b0);
        br2  = 1'b0;
        check("br_254", pc, 8'd254);
        check("br2_253", pc2, 8'd253);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap_255", pc, 8'd255);
        check("wrap3_0", pc2, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap_0", pc, 8'd0);

        // Single call / return
        cyc(1'b0, 1'b0, 1'b1, 8'd5, 1'b0);
        check("br_5", pc, 8'd5);
        drive(1'b0, 1'b1, 1'b0, 8'h40, 1'b0);
        #1;
        check("call_pc_next", pc_next, 8'h40);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("call_pc", pc, 8'h40);
        check("call_count", stack_count, 3'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("sub_pc", pc, 8'h42);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ret_pc", pc, 8'h06);
        check("ret_count", stack_count, 3'd0);

        // Nested calls with overflow, LIFO returns, underflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, call_tgt[i], 1'b0);
            check($sformatf("ncall_pc_%0d", i), pc, call_tgt[i]);
        end
        check("ovf_flag", stack_overflow, 1'b1);
        check("ovf_count", stack_count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            check($sformatf("nret_pc_%0d", i), pc, ret_exp[i]);
            check($sformatf("nret_cnt_%0d", i), stack_count, 3'(3 - i));
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("uflow_pc_next", pc_next, 8'h12);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("uflow_pc", pc, 8'h12);
        check("uflow_flag", stack_underflow, 1'b1);
        check("uflow_count", stack_count, 3'd0);

        // Flag clear: set-dominant, then plain clear
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_dom_uflow", stack_underflow, 1'b1);
        check("clr_ovf", stack_overflow, 1'b0);
        check("clr_dom_pc", pc, 8'h13);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_uflow", stack_underflow, 1'b0);

        // Priority: ret beats call and branch; stall keeps pc
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'h08, 1'b0);
        check("prio_call_pc", pc, 8'h08);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("prio_pc9", pc, 8'h09);
        drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        #1;
        check("prio_pc_next", pc_next, 8'h01);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("prio_pc", pc, 8'h01);
        check("prio_count", stack_count, 3'd0);
        check("prio_ovf", stack_overflow, 1'b0);
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        #1;
        check("stall_pc_next", pc_next, 8'h77);
        step();
        check("stall_pc", pc, 8'h01);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        check("stall_uflow", stack_underflow, 1'b0);
        check("stall_pc2", pc, 8'h01);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
